// File: rtl/traffic_seq_pkg.sv
// Shared types and constants for the traffic phase sequencer: phase encoding,
// io pin indices and the lamp pattern driven in each phase.
package traffic_seq_pkg;

  typedef enum logic [2:0] {
    ST_RED2      = 3'd0,
    ST_WALK      = 3'd1,
    ST_NS_GREEN  = 3'd2,
    ST_NS_YELLOW = 3'd3,
    ST_RED1      = 3'd4,
    ST_EW_GREEN  = 3'd5,
    ST_EW_YELLOW = 3'd6,
    ST_FLASH     = 3'd7
  } phase_e;

  localparam int IN_CLK   = 0;
  localparam int IN_RST   = 1;
  localparam int IN_PED   = 2;
  localparam int IN_NIGHT = 3;
  localparam int IN_FAST  = 4;

  localparam int IO_NS_RED    = 0;
  localparam int IO_NS_YELLOW = 1;
  localparam int IO_NS_GREEN  = 2;
  localparam int IO_EW_RED    = 3;
  localparam int IO_EW_YELLOW = 4;
  localparam int IO_EW_GREEN  = 5;
  localparam int IO_WALK      = 6;
  localparam int IO_HEARTBEAT = 7;

  localparam int LAMP_W = 7;

  localparam logic [LAMP_W-1:0] CODE_RED2      = 7'h09;
  localparam logic [LAMP_W-1:0] CODE_WALK      = 7'h49;
  localparam logic [LAMP_W-1:0] CODE_NS_GREEN  = 7'h0C;
  localparam logic [LAMP_W-1:0] CODE_NS_YELLOW = 7'h0A;
  localparam logic [LAMP_W-1:0] CODE_RED1      = 7'h09;
  localparam logic [LAMP_W-1:0] CODE_EW_GREEN  = 7'h21;
  localparam logic [LAMP_W-1:0] CODE_EW_YELLOW = 7'h11;
  localparam logic [LAMP_W-1:0] CODE_FLASH_ON  = 7'h12;
  localparam logic [LAMP_W-1:0] CODE_DARK      = 7'h00;

  // Phases where a pending pedestrian request is consumed or discarded.
  function automatic logic clears_ped(input phase_e s);
    return (s == ST_WALK) || (s == ST_FLASH);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick on counter wrap, or every
// cycle in fast mode; the counter MSB doubles as a visible heartbeat.
module tick_prescaler #(
  parameter int PRESCALE_W = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic fast,
  output logic tick,
  output logic msb
);

  logic [PRESCALE_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count + PRESCALE_W'(1);
    end
  end

  // Fast mode only overrides the tick; the counter keeps running for the heartbeat.
  assign tick = fast | (&count);
  assign msb  = count[PRESCALE_W-1];

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-way junction light sequencer with pedestrian walk and night flash,
// clocked from io_in[0] and advanced one phase-timer step per prescaler tick.
module traffic_phase_sequencer
  import traffic_seq_pkg::*;
#(
  parameter int PRESCALE_W   = 14,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 4,
  parameter int PHASE_W      = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic clk;
  logic rst;
  assign clk = io_in[IN_CLK];
  assign rst = io_in[IN_RST];

  logic [2:0] async_in;
  logic [2:0] sync_p0;
  logic [2:0] sync_p1;
  logic       ped_s;
  logic       night_s;
  logic       fast_s;
  logic       unused_in;

  assign async_in  = io_in[IN_FAST:IN_PED];
  assign unused_in = ^io_in[7:5];

  // Stage p0/p1: two-flop synchronizers, left unreset so they never gate startup.
  always_ff @(posedge clk) begin
    sync_p0 <= async_in;
    sync_p1 <= sync_p0;
  end

  assign ped_s   = sync_p1[0];
  assign night_s = sync_p1[1];
  assign fast_s  = sync_p1[2];

  logic tick;
  logic heartbeat;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(rst),
    .fast (fast_s),
    .tick (tick),
    .msb  (heartbeat)
  );

  function automatic logic [PHASE_W-1:0] load_of(input phase_e s);
    case (s)
      ST_WALK:                     return PHASE_W'(WALK_TICKS - 1);
      ST_NS_GREEN, ST_EW_GREEN:    return PHASE_W'(GREEN_TICKS - 1);
      ST_NS_YELLOW, ST_EW_YELLOW:  return PHASE_W'(YELLOW_TICKS - 1);
      default:                     return PHASE_W'(ALLRED_TICKS - 1);
    endcase
  endfunction

  function automatic phase_e successor(input phase_e s, input logic ped_pending);
    case (s)
      ST_RED2:      return ped_pending ? ST_WALK : ST_NS_GREEN;
      ST_WALK:      return ST_NS_GREEN;
      ST_NS_GREEN:  return ST_NS_YELLOW;
      ST_NS_YELLOW: return ST_RED1;
      ST_RED1:      return ST_EW_GREEN;
      ST_EW_GREEN:  return ST_EW_YELLOW;
      ST_EW_YELLOW: return ST_RED2;
      default:      return ST_RED2;
    endcase
  endfunction

  phase_e               state;
  phase_e               state_n;
  logic [PHASE_W-1:0]   timer;
  logic [PHASE_W-1:0]   timer_n;
  logic                 flash;
  logic                 flash_n;
  logic                 ped_latch;
  logic                 ped_latch_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RED2;
      timer     <= load_of(ST_RED2);
      flash     <= 1'b0;
      ped_latch <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      flash     <= flash_n;
      ped_latch <= ped_latch_n;
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    flash_n     = flash;
    ped_latch_n = ped_latch | ped_s;

    if (tick && night_s) begin
      // Night overrides any phase, including one that is expiring on this tick.
      state_n = ST_FLASH;
      timer_n = '0;
      flash_n = (state == ST_FLASH) ? ~flash : 1'b1;
    end else if (tick) begin
      if (state == ST_FLASH) begin
        state_n = ST_RED2;
        timer_n = load_of(ST_RED2);
      end else if (timer == '0) begin
        state_n = successor(state, ped_latch);
        timer_n = load_of(state_n);
      end else begin
        timer_n = timer - PHASE_W'(1);
      end
    end

    if (clears_ped(state) || clears_ped(state_n)) begin
      ped_latch_n = 1'b0;
    end
  end

  logic [LAMP_W-1:0] lamps;

  always_comb begin
    lamps = CODE_RED2;
    case (state)
      ST_RED2:      lamps = CODE_RED2;
      ST_WALK:      lamps = CODE_WALK;
      ST_NS_GREEN:  lamps = CODE_NS_GREEN;
      ST_NS_YELLOW: lamps = CODE_NS_YELLOW;
      ST_RED1:      lamps = CODE_RED1;
      ST_EW_GREEN:  lamps = CODE_EW_GREEN;
      ST_EW_YELLOW: lamps = CODE_EW_YELLOW;
      ST_FLASH:     lamps = flash ? CODE_FLASH_ON : CODE_DARK;
      default:      lamps = CODE_RED2;
    endcase
  end

  assign io_out = {heartbeat, lamps};

endmodule
